// File: rtl/uc_seq.sv
// rtl/uc_seq.sv - sequenced control unit for the single-cycle microc datapath
module uc_seq #(
    parameter int OPW          = 6,
    parameter int CNTW         = 16,
    parameter int START_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            z,
    output logic            s_abs,
    output logic            s_inc,
    output logic            s_inm,
    output logic            we3,
    output logic            wez,
    output logic [2:0]      op,
    output logic            halted,
    output logic            illegal,
    output logic [CNTW-1:0] icount
);

    localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SCW-1:0] START_LAST = SCW'(START_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t          state_q;
    logic [SCW-1:0]  start_cnt_q;
    logic            illegal_q;
    logic            halted_q;
    logic [CNTW-1:0] icount_q;

    logic [5:0] opc;
    logic       is_alu;
    logic       is_li;
    logic       is_jmp;
    logic       is_nop;
    logic       is_halt;
    logic       is_legal;
    logic       start_done;

    assign opc      = opcode[5:0];
    assign is_alu   = ~opc[5];
    assign is_li    = (opc[5:2] == 4'b1000);
    assign is_jmp   = (opc[5:2] == 4'b1001);
    assign is_nop   = (opc == 6'b101000);
    assign is_halt  = (opc == 6'b111111);
    assign is_legal = is_alu | is_li | is_jmp | is_nop | is_halt;

    // A zero-length start phase still spends exactly one edge in START.
    assign start_done = (START_CYCLES == 0) || (start_cnt_q == START_LAST);

    always_comb begin
        s_abs = 1'b0;
        s_inc = 1'b1;
        s_inm = 1'b0;
        we3   = 1'b0;
        wez   = 1'b0;
        op    = 3'b000;
        case (state_q)
            ST_RUN: begin
                if (is_alu) begin
                    op  = opc[4:2];
                    we3 = 1'b1;
                    wez = 1'b1;
                end else if (is_li) begin
                    s_inm = 1'b1;
                    we3   = 1'b1;
                end else if (is_jmp) begin
                    case (opc[1:0])
                        2'b00: begin s_abs = 1'b1; s_inc = 1'b0; end
                        2'b01: begin s_abs = 1'b1; s_inc = ~z;   end
                        2'b10: begin s_abs = 1'b1; s_inc = z;    end
                        default: begin s_abs = 1'b0; s_inc = 1'b0; end
                    endcase
                end else if (is_halt) begin
                    s_inc = 1'b0;
                end
            end
            // HALT re-issues a zero-offset relative jump so the PC stays put.
            ST_HALT: s_inc = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_START;
            start_cnt_q <= '0;
            illegal_q   <= 1'b0;
            halted_q    <= 1'b0;
            icount_q    <= '0;
        end else begin
            case (state_q)
                ST_START: begin
                    start_cnt_q <= start_cnt_q + 1'b1;
                    if (start_done) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    icount_q <= icount_q + 1'b1;
                    if (!is_legal) begin
                        illegal_q <= 1'b1;
                    end
                    if (is_halt) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALT: ;
                default: state_q <= ST_START;
            endcase
        end
    end

    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign icount  = icount_q;

endmodule

// File: tb/tb_uc_seq.sv
// tb/tb_uc_seq.sv - randomized self-checking bench for uc_seq against a behavioural model
module tb_uc_seq;

    localparam int START_CYCLES = 2;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       z;

    logic        a_abs, a_inc, a_inm, a_we3, a_wez, a_halted, a_illegal;
    logic [2:0]  a_op;
    logic [15:0] a_icount;
    logic        b_abs, b_inc, b_inm, b_we3, b_wez, b_halted, b_illegal;
    logic [2:0]  b_op;
    logic [3:0]  b_icount;

    uc_seq #(.OPW(6), .CNTW(16), .START_CYCLES(START_CYCLES)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z),
        .s_abs(a_abs), .s_inc(a_inc), .s_inm(a_inm), .we3(a_we3), .wez(a_wez),
        .op(a_op), .halted(a_halted), .illegal(a_illegal), .icount(a_icount)
    );

    uc_seq #(.OPW(6), .CNTW(4), .START_CYCLES(START_CYCLES)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z),
        .s_abs(b_abs), .s_inc(b_inc), .s_inm(b_inm), .we3(b_we3), .wez(b_wez),
        .op(b_op), .halted(b_halted), .illegal(b_illegal), .icount(b_icount)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: mode 0 = starting, 1 = running, 2 = halted.
    int m_mode;
    int m_start_edges;
    int m_count;
    bit m_ill;

    localparam int C_ALU = 0, C_LI = 1, C_J = 2, C_JZ = 3, C_JNZ = 4,
                   C_JR = 5, C_NOP = 6, C_HALT = 7, C_ILL = 8;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input int v);
        if (v < 32)  return C_ALU;
        if (v < 36)  return C_LI;
        if (v == 36) return C_J;
        if (v == 37) return C_JZ;
        if (v == 38) return C_JNZ;
        if (v == 39) return C_JR;
        if (v == 40) return C_NOP;
        if (v == 63) return C_HALT;
        return C_ILL;
    endfunction

    // Packed as {s_abs, s_inc, s_inm, we3, wez, op[2:0]}.
    function automatic logic [7:0] exp_ctl(input int mode, input int v, input bit zz);
        bit abs_b, inc_b, inm_b, we3_b, wez_b;
        int alu;
        abs_b = 0; inc_b = 1; inm_b = 0; we3_b = 0; wez_b = 0; alu = 0;
        if (mode == 2) begin
            inc_b = 0;
        end else if (mode == 1) begin
            case (classify(v))
                C_ALU:  begin alu = v / 4; we3_b = 1; wez_b = 1; end
                C_LI:   begin inm_b = 1; we3_b = 1; end
                C_J:    begin abs_b = 1; inc_b = 0; end
                C_JZ:   begin abs_b = 1; inc_b = !zz; end
                C_JNZ:  begin abs_b = 1; inc_b = zz; end
                C_JR:   inc_b = 0;
                C_HALT: inc_b = 0;
                default: ;
            endcase
        end
        return {abs_b, inc_b, inm_b, we3_b, wez_b, 3'(alu)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_start_edges = 0; m_count = 0; m_ill = 0;
    endtask

    task automatic model_edge(input int v);
        if (m_mode == 0) begin
            m_start_edges++;
            if (m_start_edges >= ((START_CYCLES == 0) ? 1 : START_CYCLES)) m_mode = 1;
        end else if (m_mode == 1) begin
            m_count++;
            if (classify(v) == C_ILL) m_ill = 1;
            if (v == 63) m_mode = 2;
        end
    endtask

    task automatic check_ctl();
        logic [7:0] e;
        e = exp_ctl(m_mode, int'(opcode), z);
        check("ctl_a", {a_abs, a_inc, a_inm, a_we3, a_wez, a_op}, e);
        check("ctl_b", {b_abs, b_inc, b_inm, b_we3, b_wez, b_op}, e);
    endtask

    task automatic check_regs();
        check("halted_a", a_halted, (m_mode == 2));
        check("halted_b", b_halted, (m_mode == 2));
        check("illegal_a", a_illegal, m_ill);
        check("illegal_b", b_illegal, m_ill);
        check("icount_a", a_icount, m_count % 65536);
        check("icount_b", b_icount, m_count % 16);
    endtask

    // Entered just after a falling edge; leaves at the next falling edge.
    task automatic step(input logic [5:0] opc, input logic zz);
        opcode = opc;
        z = zz;
        #1 check_ctl();
        @(posedge clk);
        model_edge(int'(opc));
        #1 check_regs();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        #1 reset = 1'b0;
        model_reset();
        #1;
        check("rst_we3", a_we3, 1'b0);
        check("rst_icount", a_icount, 32'd0);
        check("rst_illegal", a_illegal, 1'b0);
        check_ctl();
        check_regs();
        reset = 1'b1;
    endtask

    function automatic logic [5:0] rand_nonhalt();
        return 6'($urandom_range(0, 62));
    endfunction

    initial begin
        model_reset();
        reset  = 1'b0;
        opcode = 6'b000100;
        z      = 1'b0;
        #12;
        check_ctl();
        check_regs();
        #3 reset = 1'b1;

        repeat (3) step(6'b000100, 1'b0);
        check("add_icount", a_icount, 32'd1);
        step(6'b100000, 1'b0);
        step(6'b011000, 1'b1);
        step(6'b100101, 1'b1);
        step(6'b100101, 1'b0);
        step(6'b100110, 1'b1);
        step(6'b100110, 1'b0);
        step(6'b101101, 1'b0);
        step(6'b000100, 1'b0);
        step(6'b100001, 1'b1);
        step(6'b100100, 1'b0);
        step(6'b101000, 1'b1);
        step(6'b100111, 1'b0);
        check("illegal_sticky", a_illegal, 1'b1);

        repeat (150) step(rand_nonhalt(), 1'($urandom));
        step(6'b111111, 1'b0);
        repeat (3) step(6'b000100, 1'($urandom));

        reset_pulse();
        repeat (START_CYCLES + 17) step(6'($urandom_range(0, 40)), 1'($urandom));
        check("wrap_b", b_icount, 32'd1);

        repeat (120) begin
            if ($urandom_range(0, 19) == 0) step(6'b111111, 1'($urandom));
            else                            step(rand_nonhalt(), 1'($urandom));
        end

        reset_pulse();
        repeat (6) step(rand_nonhalt(), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uc_seq.md
Name: uc_seq

Overview:
- Sequenced control unit for the single-cycle microcontroller datapath (microc).
- Consumes the datapath's opcode[5:0] and registered zero flag z. Drives s_abs, s_inc, s_inm, we3, wez and op[2:0].
- Adds a start-up state machine, HALT handling, sticky illegal-opcode detection and a retired-instruction counter for bring-up and debug.

Parameters:
- OPW, 6, opcode width; must match the datapath opcode field.
- CNTW, 16, width of the retired-instruction counter.
- START_CYCLES, 2, cycles spent in START after reset release, with all writes suppressed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  OPW  current instruction opcode from the datapath.
- z  in  1  datapath zero flag (already registered in the datapath).
- s_abs  out  1  1 = absolute jump target, 0 = relative.
- s_inc  out  1  1 = PC+1, 0 = jump target.
- s_inm  out  1  1 = immediate to register file, 0 = ALU result.
- we3  out  1  register-file write enable.
- wez  out  1  zero-flag write enable.
- op  out  3  ALU operation.
- halted  out  1  high while the FSM is in HALT.
- illegal  out  1  sticky; set by an undefined opcode seen in RUN.
- icount  out  CNTW  instructions retired in RUN.

Behaviour:
- Control outputs are combinational from state, opcode and z, because the datapath is single-cycle. halted, illegal and icount are registered.
- Reset asserted (reset=0), asynchronous:
  - state=START, start counter=0, illegal=0, icount=0.
  - Outputs forced to s_inc=1, s_abs=0, s_inm=0, we3=0, wez=0, op=000, halted=0.
- START:
  - Outputs as in reset; the PC advances, nothing is written.
  - Counter increments each cycle. When counter==START_CYCLES-1, go to RUN on the next edge.
  - If START_CYCLES=0, go directly to RUN after the first edge.
- RUN, decode of opcode:
  - 0ooo xx: ALU reg-reg. op=ooo (opcode[4:2]), s_inm=0, we3=1, wez=1, s_inc=1.
  - 1000 xx: LI. s_inm=1, we3=1, wez=0, s_inc=1, op=000.
  - 100100: J. s_inc=0, s_abs=1.
  - 100101: JZ. s_abs=1; s_inc=~z.
  - 100110: JNZ. s_abs=1; s_inc=z.
  - 100111: JR. s_inc=0, s_abs=0.
  - 101000: NOP. s_inc=1, no writes.
  - 111111: HALT. Emits JR (s_inc=0, s_abs=0, no writes); the HALT instruction word carries a zero offset, so the PC holds. Next state is HALT.
  - Jumps and NOP: we3=0, wez=0, s_inm=0, op=000.
  - Any other opcode is illegal: behaves as NOP, and illegal<=1 on the edge (sticky until reset).
- icount: increments by 1 on each clk edge while in RUN, including illegal opcodes and the HALT opcode itself. Wraps 2^CNTW-1 -> 0 silently.
- HALT:
  - Outputs as for the HALT opcode, regardless of the incoming opcode. halted=1.
  - icount frozen. Exit only via reset.
- Conditional jumps sample z combinationally in the same cycle. The z change from an ALU op is visible to the next instruction.
- Reset asserted mid-instruction: all outputs go to reset values immediately, without waiting for a clock edge.

Test Plan:
1. reset=0 for 15 ns, then released with START_CYCLES=2 and opcode=000100 (ADD) -> we3=0, wez=0, s_inc=1 for the first 2 edges. Third cycle: we3=1, wez=1, op=001, s_inm=0. icount=1 after that edge.
2. RUN with opcode=100000 (LI), then 011000 (ALU op=110) -> LI: s_inm=1, we3=1, wez=0. Then s_inm=0, wez=1, op=110.
3. opcode=100101 with z=1, then z=0; opcode=100110 with z=1, then z=0 -> s_inc = 0, 1, 1, 0 respectively; s_abs=1 throughout, we3=0.
4. opcode=101101 (undefined) -> same-cycle outputs equal NOP. illegal=1 after the edge and stays 1 through 5 further valid opcodes. icount still increments.
5. opcode=111111, then opcode=000100 -> halted=1 from the next edge. Outputs stay s_inc=0, s_abs=0, we3=0, wez=0. icount frozen at its value +1.
6. CNTW=4: run 17 instructions -> icount reads 1. Then pulse reset low between clock edges -> icount=0, illegal=0, we3=0 immediately, without a clock edge.
